multi_tick_divider: RTL and testbench
=====================================

// Module: multi_tick_divider
// PURPOSE
//  Parametrised N-channel clock-enable/tick generator; successor to the single fixed-divisor divider.
//  Each channel divides clk by a runtime-programmable divisor and emits a 1-cycle tick and a 50% square.
//  Feeds frame/animation/hex-scan timing in the HDMI/USB top. Never used as a real clock, only as an enable.
// PARAMETERS
//  NUM_CH       4        number of independent channels
//  CNT_W        24       counter/divisor width; max divisor 2**CNT_W-1
//  DEFAULT_DIV  416666   active divisor loaded into every channel at reset
// PORTS
//  clk        in   1              system clock; all logic on posedge
//  rst_n      in   1              asynchronous, active-low reset
//  en         in   NUM_CH         per-channel run enable
//  mode_sq    in   NUM_CH         1: clk_out toggles at terminal count; 0: clk_out mirrors tick
//  div_in     in   NUM_CH*CNT_W   divisor write data, channel i at [i*CNT_W +: CNT_W]
//  div_we     in   NUM_CH         divisor write strobe, 1 cycle, per channel
//  restart    in   1              synchronous phase-align of all channels
//  tick       out  NUM_CH         1-cycle pulse per period, registered
//  clk_out    out  NUM_CH         divided waveform, registered
//  pend       out  NUM_CH         shadow divisor written but not yet applied
// BEHAVIOUR
//  - Reset (async assert, sync release): cnt=0, active_div=DEFAULT_DIV, shadow=0, tick=0, clk_out=0, pend=0.
//  - Per channel with en=1, active_div=D>=1: cnt counts 0..D-1 and wraps.
//    tick=1 for the cycle after the one where cnt==D-1, so period is exactly D cycles.
//    First tick occurs D cycles after the first enabled edge.
//  - D=1: tick stays high continuously. mode_sq=1 with D=1: clk_out toggles every cycle (clk/2).
//  - mode_sq=1: clk_out toggles with every tick (period 2D). mode_sq=0: clk_out==tick.
//    A mode change takes effect at the next tick; clk_out is not re-phased.
//  - D=0 (active): channel is stalled; cnt held at 0, tick=0, clk_out holds its value.
//  - div_we: div_in captured into shadow, pend=1. The shadow is applied (active_div<=shadow, pend=0):
//    (a) on the terminal-count cycle (glitch-free mid-run change);
//    (b) immediately if en=0 or active D=0.
//    If div_we coincides with terminal count, the new value applies at that wrap.
//    Back-to-back writes: the last write wins.
//  - en=0: cnt cleared to 0, tick=0, clk_out=0 next cycle. Re-enable restarts the period from 0.
//  - restart=1: all cnt<=0, tick<=0, clk_out<=0, pending shadows applied. Channels are phase-aligned afterwards.
//    restart has priority over terminal count and div_we in the same cycle;
//    that same-cycle div_we goes to shadow and is applied by the restart.
//  - Counter arithmetic is unsigned CNT_W; the compare is cnt==active_div-1 (no overflow for D>=1).
//  - No combinational path from input to output; every output is a flop.
// STRUCTURE
//  - Package tick_div_pkg: CNT_W default, DEFAULT_DIV constant, typedef logic [CNT_W-1:0] div_t.
//  - Sub-module tick_div_channel (one channel: cnt, active/shadow regs, tick/clk_out/pend flops).
//    Instantiated NUM_CH times via generate; the top handles only div_in slicing and restart fan-out.
// TESTING
//  1 NUM_CH=4, D={1,2,3,5} set via div_we then restart, en=all
//    -> ch0 tick constant 1; ch1..3 ticks every 2/3/5 cycles, aligned after restart.
//  2 ch0 D=4 running, div_we D=6 mid-period
//    -> pend=1 until the next tick; the current period is still 4, the following periods are 6.
//  3 mode_sq=1, D=3
//    -> clk_out high 3 low 3 (period 6), transitions coincide with tick.
//  4 en dropped for 5 cycles at cnt=2, then raised (D=4)
//    -> outputs 0 while disabled; first tick 4 cycles after re-enable.
//  5 Write D=0 -> channel stalls (no tick, clk_out frozen); write D=2 -> applied immediately, ticks resume.
//  6 rst_n asserted mid-period, asynchronously between edges
//    -> all outputs 0 immediately; after release, period=DEFAULT_DIV (use a small DEFAULT_DIV override, e.g. 7).

Source files
------------

// File: rtl/tick_div_pkg.sv
// Shared constants and types for the multi-channel tick/clock-enable divider.
package tick_div_pkg;

   localparam int DFLT_CNT_W = 24;
   localparam int DFLT_DIV   = 416666;

   typedef logic [DFLT_CNT_W-1:0] div_t;

   // Per-cycle operating condition of one channel.
   typedef enum logic [1:0] {
      OP_CLEAR = 2'd0,
      OP_STALL = 2'd1,
      OP_RUN   = 2'd2
   } ch_op_e;

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: counter, active/shadow divisor, and registered tick/clk_out/pend.
module tick_div_channel
   import tick_div_pkg::*;
#(
   parameter int CNT_W       = DFLT_CNT_W,
   parameter int DEFAULT_DIV = DFLT_DIV
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             mode_sq_i,
   input  logic [CNT_W-1:0] div_in_i,
   input  logic             div_we_i,
   input  logic             restart_i,
   output logic             tick_o,
   output logic             clk_out_o,
   output logic             pend_o
);

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             clk_q, clk_d;
   logic             mode_q, mode_d;

   logic [CNT_W-1:0] shd_eff;
   logic             pend_eff;
   logic             stalled;
   logic             term;
   ch_op_e           op;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      cnt_d    = cnt_q;
      act_d    = act_q;
      shd_d    = shd_q;
      pend_d   = pend_q;
      tick_d   = tick_q;
      clk_d    = clk_q;
      mode_d   = mode_q;
      op       = OP_RUN;

      shd_eff  = div_we_i ? div_in_i : shd_q;
      pend_eff = div_we_i | pend_q;
      stalled  = (act_q == '0);
      term     = en_i && !stalled && (cnt_q == act_q - ONE);

      if (restart_i || !en_i) begin
         op = OP_CLEAR;
      end else if (stalled) begin
         op = OP_STALL;
      end

      // A pending divisor lands only where it cannot shorten or split a running period.
      shd_d  = shd_eff;
      pend_d = pend_eff;
      if (pend_eff && (restart_i || !en_i || stalled || term)) begin
         act_d  = shd_eff;
         pend_d = 1'b0;
      end

      case (op)
         OP_CLEAR: begin
            cnt_d  = '0;
            tick_d = 1'b0;
            clk_d  = 1'b0;
         end
         OP_STALL: begin
            cnt_d  = '0;
            tick_d = 1'b0;
         end
         OP_RUN: begin
            if (term) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               mode_d = mode_sq_i;
               clk_d  = mode_sq_i ? ~clk_q : 1'b1;
            end else begin
               cnt_d  = cnt_q + ONE;
               tick_d = 1'b0;
               clk_d  = mode_q & clk_q;
            end
         end
         default: begin
            cnt_d  = '0;
            tick_d = 1'b0;
            clk_d  = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         act_q  <= RST_DIV;
         shd_q  <= '0;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         clk_q  <= 1'b0;
         mode_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
         mode_q <= mode_d;
      end
   end

   assign tick_o    = tick_q;
   assign clk_out_o = clk_q;
   assign pend_o    = pend_q;

endmodule

// File: rtl/multi_tick_divider.sv
// N-channel tick / clock-enable generator with runtime divisors; outputs are enables, never clocks.
module multi_tick_divider
   import tick_div_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = DFLT_CNT_W,
   parameter int DEFAULT_DIV = DFLT_DIV
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       mode_sq,
   input  logic [NUM_CH*CNT_W-1:0] div_in,
   input  logic [NUM_CH-1:0]       div_we,
   input  logic                    restart,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       pend
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tick_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_i      (en[i]),
         .mode_sq_i (mode_sq[i]),
         .div_in_i  (div_in[i*CNT_W +: CNT_W]),
         .div_we_i  (div_we[i]),
         .restart_i (restart),
         .tick_o    (tick[i]),
         .clk_out_o (clk_out[i]),
         .pend_o    (pend[i])
      );
   end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Directed scoreboard bench for multi_tick_divider: expectations derived from divisor arithmetic.
module tb_multi_tick_divider;
   import tick_div_pkg::*;

   localparam int NCH  = 4;
   localparam int CW   = DFLT_CNT_W;
   localparam int DDIV = 7;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NCH-1:0]      en, mode_sq, div_we;
   logic [NCH*CW-1:0]   div_in;
   logic                restart;
   logic [NCH-1:0]      tick, clk_out, pend;

   typedef struct {
      string          tag;
      logic [NCH-1:0] tick;
      logic [NCH-1:0] clk;
      logic [NCH-1:0] pend;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   multi_tick_divider #(
      .NUM_CH      (NCH),
      .CNT_W       (CW),
      .DEFAULT_DIV (DDIV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode_sq (mode_sq),
      .div_in  (div_in),
      .div_we  (div_we),
      .restart (restart),
      .tick    (tick),
      .clk_out (clk_out),
      .pend    (pend)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [NCH-1:0] t, input logic [NCH-1:0] c,
                       input logic [NCH-1:0] p);
      exp_t e;
      e.tag  = tag;
      e.tick = t;
      e.clk  = c;
      e.pend = p;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      assert (tick === e.tick) else begin
         n_fail++;
         $error("FAIL %s tick observed=%b expected=%b", e.tag, tick, e.tick);
      end
      n_cmp++;
      assert (clk_out === e.clk) else begin
         n_fail++;
         $error("FAIL %s clk_out observed=%b expected=%b", e.tag, clk_out, e.clk);
      end
      n_cmp++;
      assert (pend === e.pend) else begin
         n_fail++;
         $error("FAIL %s pend observed=%b expected=%b", e.tag, pend, e.pend);
      end
   endtask

   // Expectation is queued with the stimulus, then retired one edge later.
   task automatic step(input string tag, input logic [NCH-1:0] t, input logic [NCH-1:0] c,
                       input logic [NCH-1:0] p);
      push(tag, t, c, p);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   task automatic check_now(input string tag, input logic [NCH-1:0] t, input logic [NCH-1:0] c,
                            input logic [NCH-1:0] p);
      push(tag, t, c, p);
      check_pop();
   endtask

   task automatic set_div(input int ch, input div_t d);
      div_in[ch*CW +: CW] = d;
   endtask

   initial begin
      int             dv1[NCH];
      logic [NCH-1:0] t;
      logic [NCH-1:0] c;
      logic [NCH-1:0] p;

      rst_n   = 1'b1;
      en      = '0;
      mode_sq = '0;
      div_in  = '0;
      div_we  = '0;
      restart = 1'b0;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_now("reset", '0, '0, '0);
      #3 rst_n = 1'b1;

      // 1: D={1,2,3,5} written while disabled, then restart aligns all channels
      dv1 = '{1, 2, 3, 5};
      for (int i = 0; i < NCH; i++) set_div(i, div_t'(dv1[i]));
      div_we = '1;
      step("t1_write", '0, '0, '0);
      div_we  = '0;
      en      = '1;
      restart = 1'b1;
      step("t1_restart", '0, '0, '0);
      restart = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         t = '0;
         for (int i = 0; i < NCH; i++) t[i] = ((n % dv1[i]) == 0);
         step($sformatf("t1_n%0d", n), t, t, '0);
      end

      // 2: ch0 D=4, mid-period write of 6 waits for the next wrap
      en = '0;
      set_div(0, div_t'(4));
      div_we = 4'b0001;
      step("t2_setup", '0, '0, '0);
      div_we = '0;
      en     = 4'b0001;
      for (int n = 1; n <= 21; n++) begin
         div_we = (n == 6) ? 4'b0001 : 4'b0000;
         if (n == 6) set_div(0, div_t'(6));
         t = {3'b000, (n == 4 || n == 8 || n == 14 || n == 20)};
         p = {3'b000, (n == 6 || n == 7)};
         step($sformatf("t2_n%0d", n), t, t, p);
      end
      div_we = '0;

      // 3: square mode with D=3 gives 3 high / 3 low
      en      = '0;
      mode_sq = 4'b0001;
      set_div(0, div_t'(3));
      div_we  = 4'b0001;
      step("t3_setup", '0, '0, '0);
      div_we = '0;
      en     = 4'b0001;
      for (int n = 1; n <= 18; n++) begin
         t = {3'b000, ((n % 3) == 0)};
         c = {3'b000, (((n / 3) % 2) == 1)};
         step($sformatf("t3_n%0d", n), t, c, '0);
      end

      // 4: disable at cnt=2 for 5 cycles, re-enable restarts the period
      en      = '0;
      mode_sq = '0;
      set_div(0, div_t'(4));
      div_we  = 4'b0001;
      step("t4_setup", '0, '0, '0);
      div_we = '0;
      en     = 4'b0001;
      step("t4_run1", '0, '0, '0);
      step("t4_run2", '0, '0, '0);
      en = '0;
      for (int n = 1; n <= 5; n++) step($sformatf("t4_off%0d", n), '0, '0, '0);
      en = 4'b0001;
      for (int m = 1; m <= 8; m++) begin
         t = {3'b000, (m == 4 || m == 8)};
         step($sformatf("t4_m%0d", m), t, t, '0);
      end

      // 5: D=0 stalls with clk_out frozen high; D=2 then applies at once
      en      = '0;
      mode_sq = 4'b0001;
      set_div(0, div_t'(2));
      div_we  = 4'b0001;
      step("t5_setup", '0, '0, '0);
      en = 4'b0001;
      for (int n = 1; n <= 16; n++) begin
         div_we = (n == 1 || n == 9) ? 4'b0001 : 4'b0000;
         if (n == 1) set_div(0, div_t'(0));
         if (n == 9) set_div(0, div_t'(2));
         t = {3'b000, (n == 2 || (n >= 11 && (n % 2) == 1))};
         if (n == 1)       c = 4'b0000;
         else if (n <= 10) c = 4'b0001;
         else              c = {3'b000, ((((n - 11) / 2) % 2) == 1)};
         p = {3'b000, (n == 1)};
         step($sformatf("t5_n%0d", n), t, c, p);
      end
      div_we = '0;

      // 6: async reset mid-period, then every channel runs at DEFAULT_DIV
      en      = '1;
      mode_sq = '0;
      restart = 1'b1;
      step("t6_restart", '0, '0, '0);
      restart = 1'b0;
      step("t6_n1", 4'b0000, 4'b0000, '0);
      step("t6_n2", 4'b0011, 4'b0011, '0);
      step("t6_n3", 4'b0100, 4'b0100, '0);
      #3 rst_n = 1'b0;
      #1 check_now("t6_async", '0, '0, '0);
      #2 rst_n = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         t = ((n % DDIV) == 0) ? '1 : '0;
         step($sformatf("t6_dflt_n%0d", n), t, t, '0);
      end

      // 7: restart with a same-cycle write applies the write immediately
      restart = 1'b1;
      set_div(1, div_t'(3));
      div_we  = 4'b0010;
      step("t7_restart_we", '0, '0, '0);
      restart = 1'b0;
      div_we  = '0;
      for (int n = 1; n <= 8; n++) begin
         t = ((n % DDIV) == 0) ? 4'b1101 : 4'b0000;
         t[1] = ((n % 3) == 0);
         step($sformatf("t7_n%0d", n), t, t, '0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
